// File: rtl/sha_mem_responder.sv
// Memory-side responder for the SHA-256 engine: loads a message from the host, kicks the
// engine, serves its word-addressed reads/writes and streams the 8-word digest back.
module sha_mem_responder #(
  parameter int NUM_WORDS = 20,
  parameter int DEPTH     = 64,
  parameter int MSG_BASE  = 0,
  parameter int OUT_BASE  = 32,
  parameter int TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        start,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  input  logic        done,
  input  logic [15:0] mem_addr,
  input  logic        mem_we,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_range
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {LOAD, KICK, WAIT_ACK, WAIT_DONE, DRAIN} state_t;

  logic [31:0] ram [DEPTH];

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          start_q, start_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [31:0]   out_data_q, out_data_d;
  logic [31:0]   mem_read_data_q, mem_read_data_d;
  logic          err_timeout_q, err_timeout_d;
  logic          err_range_q, err_range_d;

  logic          honoured, addr_ok, host_acc, wr_en;
  logic [AW-1:0] wr_addr, msg_addr, drain_addr;
  logic [31:0]   wr_data;

  // The engine owns the RAM only while it is working on a job.
  assign honoured   = (state_q == WAIT_ACK) || ((state_q == WAIT_DONE) && !done);
  assign addr_ok    = ({16'd0, mem_addr} < 32'(DEPTH));
  assign host_acc   = (state_q == LOAD) && in_valid && in_ready_q;
  assign msg_addr   = AW'(MSG_BASE) + cnt_q[AW-1:0];
  assign drain_addr = AW'(OUT_BASE) + cnt_q[AW-1:0];

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = msg_addr;
    wr_data = in_data;
    if (host_acc) begin
      wr_en = 1'b1;
    end else if (honoured && mem_we && addr_ok) begin
      wr_en   = 1'b1;
      wr_addr = mem_addr[AW-1:0];
      wr_data = mem_write_data;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    timer_d         = timer_q;
    start_d         = 1'b0;
    in_ready_d      = in_ready_q;
    out_valid_d     = out_valid_q;
    out_last_d      = out_last_q;
    out_data_d      = out_data_q;
    err_timeout_d   = err_timeout_q;
    err_range_d     = err_range_q | (honoured & ~addr_ok);
    mem_read_data_d = addr_ok ? ram[mem_addr[AW-1:0]] : 32'd0;

    case (state_q)
      LOAD: begin
        if (host_acc) begin
          if (cnt_q == 16'(NUM_WORDS - 1)) begin
            cnt_d      = 16'd0;
            in_ready_d = 1'b0;
            state_d    = KICK;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      KICK: begin
        if (done) begin
          start_d = 1'b1;
          timer_d = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK, WAIT_DONE: begin
        if (timer_q == TW'(TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          cnt_d         = 16'd0;
          in_ready_d    = 1'b1;
          state_d       = LOAD;
        end else begin
          timer_d = timer_q + 1'b1;
          if ((state_q == WAIT_ACK) && !done) begin
            state_d = WAIT_DONE;
          end else if ((state_q == WAIT_DONE) && done) begin
            // Prefetch digest word 0 so out_valid is up on the first DRAIN cycle.
            out_data_d  = ram[AW'(OUT_BASE)];
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            cnt_d       = 16'd1;
            state_d     = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            cnt_d       = 16'd0;
            in_ready_d  = 1'b1;
            state_d     = LOAD;
          end else begin
            out_data_d = ram[drain_addr];
            out_last_d = (cnt_q == 16'd7);
            cnt_d      = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= LOAD;
      cnt_q           <= 16'd0;
      timer_q         <= '0;
      start_q         <= 1'b0;
      in_ready_q      <= 1'b1;
      out_valid_q     <= 1'b0;
      out_last_q      <= 1'b0;
      out_data_q      <= 32'd0;
      mem_read_data_q <= 32'd0;
      err_timeout_q   <= 1'b0;
      err_range_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      timer_q         <= timer_d;
      start_q         <= start_d;
      in_ready_q      <= in_ready_d;
      out_valid_q     <= out_valid_d;
      out_last_q      <= out_last_d;
      out_data_q      <= out_data_d;
      mem_read_data_q <= mem_read_data_d;
      err_timeout_q   <= err_timeout_d;
      err_range_q     <= err_range_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= wr_data;
  end

  assign start         = start_q;
  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign out_data      = out_data_q;
  assign mem_read_data = mem_read_data_q;
  assign err_timeout   = err_timeout_q;
  assign err_range     = err_range_q;
  assign busy          = (state_q != LOAD);
  assign message_addr  = 16'(MSG_BASE);
  assign output_addr   = 16'(OUT_BASE);

endmodule

// File: tb/tb_sha_mem_responder.sv
// Self-checking bench for sha_mem_responder: drives host streams and a simple engine model,
// comparing against a word-array model of the RAM and sticky error flags.
module tb_sha_mem_responder;

  localparam int NUM_WORDS = 20;
  localparam int DEPTH     = 64;
  localparam int MSG_BASE  = 0;
  localparam int OUT_BASE  = 32;
  localparam int TIMEOUT   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        start, done, mem_we, busy, err_timeout, err_range;
  logic [15:0] message_addr, output_addr, mem_addr;
  logic [31:0] mem_write_data, mem_read_data;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] digest [8];
  logic        exp_err_to;
  logic        exp_err_rng;

  sha_mem_responder #(
    .NUM_WORDS(NUM_WORDS), .DEPTH(DEPTH), .MSG_BASE(MSG_BASE),
    .OUT_BASE(OUT_BASE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .start(start), .message_addr(message_addr), .output_addr(output_addr),
    .done(done), .mem_addr(mem_addr), .mem_we(mem_we), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .busy(busy),
    .err_timeout(err_timeout), .err_range(err_range)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_err_to  = 1'b0;
    exp_err_rng = 1'b0;
    checkOutput("rst_start", start, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_mem_read_data", mem_read_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err_timeout", err_timeout, 0);
    checkOutput("rst_err_range", err_range, 0);
  endtask

  // Streams n message words into the responder; full=1 means the job should now be kicked.
  task automatic applyStimulus(input int n, input bit sequential, input bit full);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = sequential ? 32'(i + 1) : $urandom;
      checkOutput("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_data  = w;
      tick();
      model_mem[MSG_BASE + i] = w;
    end
    in_valid = 1'b0;
    in_data  = 32'd0;
    if (full) begin
      checkOutput("in_ready_after_load", in_ready, 0);
      checkOutput("busy_kick", busy, 1);
      checkOutput("start_early", start, 0);
    end
  endtask

  task automatic kick();
    tick();
    checkOutput("start_pulse", start, 1);
    checkOutput("busy_start", busy, 1);
  endtask

  task automatic runEngine(input logic [15:0] first_addr, input bit range_probe, input int n_writes);
    done     = 1'b0;
    mem_we   = 1'b0;
    mem_addr = first_addr;
    tick();
    checkOutput("start_one_cycle", start, 0);
    checkOutput("engine_read", mem_read_data, model_mem[int'(first_addr)]);
    if (range_probe) begin
      mem_addr = 16'd70;
      tick();
      exp_err_rng = 1'b1;
      checkOutput("range_read", mem_read_data, 0);
      checkOutput("err_range_set", err_range, exp_err_rng);
    end
    for (int k = 0; k < n_writes; k++) begin
      mem_we         = 1'b1;
      mem_addr       = 16'(OUT_BASE + k);
      mem_write_data = digest[k];
      tick();
      model_mem[OUT_BASE + k] = digest[k];
    end
    mem_we = 1'b0;
    if (n_writes == 8) begin
      done = 1'b1;
      tick();
    end
  endtask

  task automatic drainDigest(input bit toggle_ready, input bit hold_we);
    int idx   = 0;
    int cyc   = 0;
    int first = -1;
    logic rdy;
    if (hold_we) begin
      mem_we         = 1'b1;
      mem_addr       = 16'd33;
      mem_write_data = 32'hDEADBEEF;
    end
    while (idx < 8 && cyc < 64) begin
      if (first < 0 && out_valid === 1'b1) first = cyc;
      if (first >= 0) begin
        checkOutput("out_valid_held", out_valid, 1);
        checkOutput($sformatf("out_data_%0d", idx), out_data, model_mem[OUT_BASE + idx]);
        checkOutput($sformatf("out_last_%0d", idx), out_last, 32'(idx == 7));
        rdy = toggle_ready ? (((cyc - first) % 2) == 0) : 1'($urandom_range(1, 0));
        out_ready = rdy;
        if (rdy) idx++;
      end else begin
        out_ready = 1'($urandom_range(1, 0));
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    checkOutput("drain_complete", idx, 8);
    checkOutput("valid_latency_ok", 32'(first >= 0 && first <= 2), 1);
    checkOutput("post_drain_out_valid", out_valid, 0);
    checkOutput("post_drain_in_ready", in_ready, 1);
    checkOutput("post_drain_busy", busy, 0);
    checkOutput("post_drain_err_timeout", err_timeout, exp_err_to);
    checkOutput("post_drain_err_range", err_range, exp_err_rng);
  endtask

  task automatic randomDigest();
    for (int k = 0; k < 8; k++) digest[k] = $urandom;
  endtask

  task automatic fullJob();
    applyStimulus(NUM_WORDS, 1'b0, 1'b1);
    kick();
    randomDigest();
    runEngine(16'($urandom_range(NUM_WORDS - 1, 0)), 1'b0, 8);
    drainDigest(1'b0, 1'b0);
  endtask

  initial begin
    reset          = 1'b1;
    in_valid       = 1'b0;
    in_data        = 32'd0;
    out_ready      = 1'b0;
    done           = 1'b1;
    mem_addr       = 16'd0;
    mem_we         = 1'b0;
    mem_write_data = 32'd0;
    for (int a = 0; a < DEPTH; a++) model_mem[a] = 32'd0;

    doReset();
    checkOutput("message_addr", message_addr, MSG_BASE);
    checkOutput("output_addr", output_addr, OUT_BASE);

    // Job with counting message, fixed digest and 1,0,1,0 host ready
    applyStimulus(NUM_WORDS, 1'b1, 1'b1);
    kick();
    for (int k = 0; k < 8; k++) digest[k] = 32'hA0000000 + 32'(k);
    runEngine(16'd5, 1'b1, 8);
    drainDigest(1'b1, 1'b0);

    // Engine never acknowledges: abort after TIMEOUT cycles
    applyStimulus(NUM_WORDS, 1'b0, 1'b1);
    kick();
    tick();
    checkOutput("timeout_start_low", start, 0);
    for (int i = 2; i <= TIMEOUT - 1; i++) tick();
    checkOutput("timeout_not_yet", err_timeout, 0);
    checkOutput("timeout_busy_before", busy, 1);
    tick();
    exp_err_to = 1'b1;
    checkOutput("timeout_flag", err_timeout, exp_err_to);
    checkOutput("timeout_busy_after", busy, 0);
    checkOutput("timeout_in_ready", in_ready, 1);
    checkOutput("timeout_out_valid", out_valid, 0);

    // Engine holds a stray write to addr 33 through LOAD and DRAIN
    mem_we         = 1'b1;
    mem_addr       = 16'd33;
    mem_write_data = 32'hDEADBEEF;
    applyStimulus(NUM_WORDS, 1'b0, 1'b1);
    kick();
    randomDigest();
    runEngine(16'($urandom_range(NUM_WORDS - 1, 0)), 1'b0, 8);
    drainDigest(1'b0, 1'b1);
    applyStimulus(NUM_WORDS, 1'b0, 1'b1);
    kick();
    randomDigest();
    runEngine(16'd33, 1'b0, 8);
    drainDigest(1'b0, 1'b0);

    // Reset in the middle of the engine's digest writes
    applyStimulus(NUM_WORDS, 1'b0, 1'b1);
    kick();
    randomDigest();
    runEngine(16'($urandom_range(NUM_WORDS - 1, 0)), 1'b0, 3);
    done = 1'b1;
    doReset();
    fullJob();

    // Reset after a partial message load
    applyStimulus(7, 1'b0, 1'b0);
    doReset();
    fullJob();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
